// File: rtl/dcache_port_arbiter.sv
// Shares one dcache request port between NumReq requesters: index-phase arbitration,
// tag-phase steering and in-order load response routing. Define DCACHE_ARB_FIXED_PRIO_EN for fixed priority.
package dcache_arb_pkg;
  localparam int unsigned IdxW  = 12;
  localparam int unsigned TagW  = 44;
  localparam int unsigned DataW = 64;
  localparam int unsigned UserW = 1;
  localparam int unsigned IdW   = 4;

  typedef struct packed {
    logic [IdxW-1:0]    address_index;
    logic [TagW-1:0]    address_tag;
    logic [DataW-1:0]   data_wdata;
    logic [UserW-1:0]   data_wuser;
    logic               data_req;
    logic               data_we;
    logic [DataW/8-1:0] data_be;
    logic [1:0]         data_size;
    logic [IdW-1:0]     data_id;
    logic               kill_req;
    logic               tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic               data_gnt;
    logic               data_rvalid;
    logic [IdW-1:0]     data_rid;
    logic [DataW-1:0]   data_rdata;
    logic [UserW-1:0]   data_ruser;
  } dcache_req_o_t;
endpackage

module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned NumReq = 2,
  parameter int unsigned MaxOut = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  dcache_req_i_t req_i [NumReq],
  output dcache_req_o_t rsp_o [NumReq],
  output dcache_req_i_t dc_req_o,
  input  dcache_req_o_t dc_rsp_i
);

  localparam int unsigned IdxBits = $clog2(NumReq);
  localparam int unsigned PtrW    = $clog2(MaxOut) + 1;

  typedef logic [IdxBits-1:0] idx_t;
  typedef logic [PtrW-1:0]    ptr_t;

  idx_t rr_ptr_q;
  logic lock_vld_q, lock_vld_d;
  idx_t lock_idx_q, lock_idx_d;
  logic tag_vld_q,  tag_vld_d;
  idx_t tag_idx_q,  tag_idx_d;
  ptr_t wr_ptr_q,   wr_ptr_d;
  ptr_t rd_ptr_q,   rd_ptr_d;
  idx_t owner_q [MaxOut];

  idx_t win;
  idx_t head;
  logic full, empty;
  logic presented, gnt, load_gnt, pop;

  // Round-robin search from rr_ptr_q; a locked winner overrides the search.
  always_comb begin
    int unsigned cand;
    logic        found;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    win   = rr_ptr_q;
    found = 1'b0;
    cand  = 0;
    if (lock_vld_q) begin
      win = lock_idx_q;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        cand = 32'(rr_ptr_q) + k;
        if (cand >= NumReq) cand = cand - NumReq;
        if (!found && req_i[idx_t'(cand)].data_req) begin
          win   = idx_t'(cand);
          found = 1'b1;
        end
      end
    end
  end

  assign full  = (wr_ptr_q ^ rd_ptr_q) == ptr_t'(MaxOut);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = owner_q[rd_ptr_q[PtrW-2:0]];

  // A load facing a full owner FIFO is not offered to the dcache; stores always are.
  assign presented = req_i[win].data_req && !(full && !req_i[win].data_we);
  assign gnt       = presented && dc_rsp_i.data_gnt;
  assign load_gnt  = gnt && !req_i[win].data_we;
  assign pop       = dc_rsp_i.data_rvalid && !empty;

  always_comb begin
    dc_req_o = '0;
    if (!rst) begin
      dc_req_o             = req_i[win];
      dc_req_o.data_req    = presented;
      dc_req_o.address_tag = '0;
      dc_req_o.tag_valid   = 1'b0;
      dc_req_o.kill_req    = 1'b0;
      if (tag_vld_q) begin
        dc_req_o.address_tag = req_i[tag_idx_q].address_tag;
        dc_req_o.tag_valid   = req_i[tag_idx_q].tag_valid;
        dc_req_o.kill_req    = req_i[tag_idx_q].kill_req;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_o[i] = '0;
      if (!rst) begin
        rsp_o[i].data_rid    = dc_rsp_i.data_rid;
        rsp_o[i].data_rdata  = dc_rsp_i.data_rdata;
        rsp_o[i].data_ruser  = dc_rsp_i.data_ruser;
        rsp_o[i].data_gnt    = gnt && (win == idx_t'(i));
        rsp_o[i].data_rvalid = pop && (head == idx_t'(i));
      end
    end
  end

  // An offered but ungranted request pins the winner; dropping data_req releases the lock.
  always_comb begin
    lock_vld_d = presented && !gnt;
    lock_idx_d = win;
    tag_vld_d  = load_gnt;
    tag_idx_d  = win;
    wr_ptr_d   = wr_ptr_q + ptr_t'(load_gnt);
    rd_ptr_d   = rd_ptr_q + ptr_t'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      tag_vld_q  <= 1'b0;
      tag_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      // NOTE: the owner storage is small and is cleared too, so head never carries X after reset.
      for (int unsigned i = 0; i < MaxOut; i++) owner_q[i] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      tag_vld_q  <= tag_vld_d;
      tag_idx_q  <= tag_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (load_gnt) owner_q[wr_ptr_q[PtrW-2:0]] <= win;
    end
  end

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  assign rr_ptr_q = '0;
`else
  idx_t rr_ptr_d;
  assign rr_ptr_d = (win == idx_t'(NumReq - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst)      rr_ptr_q <= '0;
    else if (gnt) rr_ptr_q <= rr_ptr_d;
  end
`endif

  // An rvalid with nothing outstanding is dropped; flag it as a protocol error.
  rvalid_without_load: assert property (@(posedge clk) disable iff (rst)
    !(dc_rsp_i.data_rvalid && empty))
    else $warning("dcache_port_arbiter: rvalid with no outstanding load dropped");

endmodule
